// File: rtl/id_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_fetch
// Description : Decode-stage front end. Holds the IF->ID pipeline register,
//               an instruction hold buffer for stalls, the register file and
//               an NFWD-source forwarding network with load-use interlock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst               clock, synchronous active-high reset
//   if_valid, if_pc        fetch-stage valid and pc
//   inst_rdata             instruction SRAM data (one cycle after pc capture)
//   stall, flush           ID register hold / kill
//   rs_addr, rt_addr       source register addresses
//   wb_we/waddr/wdata      register file write port
//   fwd_we/load/waddr/wdata packed forwarding sources, index 0 youngest
//   id_valid, id_pc        ID-stage valid and pc
//   id_inst                ID-stage instruction (live or held)
//   rs_data, rt_data       resolved source operands
//   stallreq               load-use hazard request
// ============================================================================
module id_operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NFWD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          inst_rdata,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [AW-1:0]        rs_addr,
    input  logic [AW-1:0]        rt_addr,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_waddr,
    input  logic [XLEN-1:0]      wb_wdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_load,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*XLEN-1:0] fwd_wdata,
    output logic                 id_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_inst,
    output logic [XLEN-1:0]      rs_data,
    output logic [XLEN-1:0]      rt_data,
    output logic                 stallreq
);

    localparam int NREG = 2**AW;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_t;

    hold_state_t     r_state;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [31:0]     r_held;
    logic [XLEN-1:0] r_regs [NREG];

    logic [XLEN:0]   w_rs_res;
    logic [XLEN:0]   w_rt_res;

    // ID register and hold FSM. The SRAM only presents data for one cycle,
    // so the first stalled cycle copies it; later stalled cycles keep that copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_state    <= ST_RUN;
            r_held     <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_state    <= ST_RUN;
        end else if (stall) begin
            if (r_state == ST_RUN) begin
                r_held  <= inst_rdata;
                r_state <= ST_HOLD;
            end
        end else begin
            r_id_valid <= if_valid;
            r_id_pc    <= if_pc;
            r_state    <= ST_RUN;
        end
    end

    // Register file; entry 0 is never written and is masked on read anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_waddr != '0)) begin
            r_regs[wb_waddr] <= wb_wdata;
        end
    end

    // Returns {load_hit, data}. Sources are scanned oldest to youngest so the
    // youngest matching source overwrites; only the winner's load flag counts.
    function automatic logic [XLEN:0] resolve(input logic [AW-1:0] a);
        logic [XLEN:0] res;
        res = {1'b0, r_regs[a]};
        if (wb_we && (wb_waddr == a)) begin
            res = {1'b0, wb_wdata};
        end
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == a)) begin
                res = {fwd_load[i], fwd_wdata[i*XLEN +: XLEN]};
            end
        end
        if (a == '0) begin
            res = '0;
        end
        return res;
    endfunction

    always_comb begin
        w_rs_res = resolve(rs_addr);
        w_rt_res = resolve(rt_addr);
    end

    assign rs_data  = w_rs_res[XLEN-1:0];
    assign rt_data  = w_rt_res[XLEN-1:0];
    assign stallreq = r_id_valid & (w_rs_res[XLEN] | w_rt_res[XLEN]);

    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_inst  = !r_id_valid          ? 32'd0  :
                      (r_state == ST_HOLD) ? r_held : inst_rdata;

endmodule
`default_nettype wire
